// File: rtl/insn_pkg.sv
// Shared instruction-format definitions: opcodes, request kinds, field positions and
// loader/decode FSM state encoding.
package insn_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_ADDI = 2'd1,
    KIND_SW   = 2'd2,
    KIND_LW   = 2'd3
  } kind_e;

  // Low bit of each field inside the 32-bit word.
  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_LSB = 2;
  localparam int unsigned FIELD_W   = 5;
  localparam int unsigned IMM_W     = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [4:0] kind_opcode(kind_e k);
    logic [4:0] op;
    op = OP_ALU;
    case (k)
      KIND_ALU:  op = OP_ALU;
      KIND_ADDI: op = OP_ADDI;
      KIND_SW:   op = OP_SW;
      KIND_LW:   op = OP_LW;
      default:   op = OP_ALU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/insn_encode_loader_if.sv
// Request handshake and imem write port of the instruction loader.
// The loader sits on the slave side; the program source / imem on the master side.
interface insn_encode_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_shamt;
  logic [4:0]        req_aluop;
  logic [16:0]       req_imm;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs, req_rt, req_shamt, req_aluop, req_imm,
    output req_ready, imem_wren, imem_addr, imem_wdata
  );

  modport master (
    output req_valid, req_kind, req_rd, req_rs, req_rt, req_shamt, req_aluop, req_imm,
    input  req_ready, imem_wren, imem_addr, imem_wdata
  );
endinterface

// File: rtl/insn_word_pack.sv
// Combinational packer: request kind plus fields -> 32-bit instruction word
// (R-type for ALU, I-type for ADDI/SW/LW).
module insn_word_pack
  import insn_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  aluop_i,
  input  logic [16:0] imm_i,
  output logic [31:0] word_o
);

  kind_e kind;
  assign kind = kind_e'(kind_i);

  always_comb begin
    word_o = '0;
    word_o[OP_LSB +: FIELD_W] = kind_opcode(kind);
    word_o[RD_LSB +: FIELD_W] = rd_i;
    word_o[RS_LSB +: FIELD_W] = rs_i;
    if (kind == KIND_ALU) begin
      word_o[RT_LSB    +: FIELD_W] = rt_i;
      word_o[SHAMT_LSB +: FIELD_W] = shamt_i;
      word_o[ALUOP_LSB +: FIELD_W] = aluop_i;
    end else begin
      word_o[0 +: IMM_W] = imm_i;
    end
  end

endmodule

// File: rtl/insn_encode_loader.sv
// Instruction loader: packs field requests into words and writes them sequentially into imem.
// Define INSN_ENC_CHECKSUM_EN to add an XOR checksum output over all words written in a session.
module insn_encode_loader
  import insn_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              finish,
  insn_encode_loader_if.slave bus,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              full
`ifdef INSN_ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              ready;
  logic              accept;
  logic [31:0]       word;
`ifdef INSN_ENC_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  insn_word_pack u_pack (
    .kind_i  (bus.req_kind),
    .rd_i    (bus.req_rd),
    .rs_i    (bus.req_rs),
    .rt_i    (bus.req_rt),
    .shamt_i (bus.req_shamt),
    .aluop_i (bus.req_aluop),
    .imm_i   (bus.req_imm),
    .word_o  (word)
  );

  // full_q doubles as the last-address-accepted flag; it is only cleared by a new start.
  assign ready  = (state_q == ST_LOAD) && !full_q;
  assign accept = bus.req_valid && ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
`ifdef INSN_ENC_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
`ifdef INSN_ENC_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
`ifdef INSN_ENC_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          wptr_d  = start_addr;
          cnt_d   = '0;
          full_d  = 1'b0;
`ifdef INSN_ENC_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wren_d  = 1'b1;
          addr_d  = wptr_q;
          wdata_d = word;
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
`ifdef INSN_ENC_CHECKSUM_EN
          csum_d  = csum_q ^ word;
`endif
          // The top address closes the session instead of wrapping the pointer.
          if (wptr_q == '1) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            wptr_d = wptr_q + ADDR_W'(1);
          end
        end
        if (finish) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.imem_wren  = wren_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign word_count     = cnt_q;
  assign busy           = (state_q == ST_LOAD);
  assign done           = (state_q == ST_DONE);
  assign full           = full_q;
`ifdef INSN_ENC_CHECKSUM_EN
  assign checksum       = csum_q;
`endif

endmodule
